// File: rtl/fifo_buffer_ext_pkg.sv
// Purpose : shared types for the extended FIFO (per-cycle operation decode).
// Latency : n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   fifo_op_t  - the accepted operation in a cycle, encoded as {push, pop}
//   decode_op  - packs the accepted push/pop strobes into a fifo_op_t
package fifo_buffer_ext_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t decode_op(input logic push, input logic pop);
        return fifo_op_t'({push, pop});
    endfunction

endpackage

// File: rtl/fifo_buffer_ext_reg_file.sv
// Purpose : FIFO storage array, synchronous write, asynchronous read.
// Latency : write lands on the clock edge; read is combinational from the address.
// Backpressure: none; the caller only asserts i_we for accepted pushes.
//
// Ports:
//   clk      - rising-edge clock
//   i_we     - write enable (one word per cycle)
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - word stored at i_raddr
module fifo_reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Contents are deliberately not reset: only words behind a valid
    // read pointer are ever observed.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_buffer_ext.sv
// Purpose : synchronous first-word-fall-through FIFO with count, programmable almost flags, flush, sticky errors.
// Latency : a push into an empty FIFO is visible on r_data/count the cycle after the write edge.
// Backpressure: pushes while full (without a same-cycle pop) and pops while empty are dropped and flagged.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset (highest priority)
//   flush             - synchronous clear of pointers/count/empty/full; errors and memory kept
//   wr, w_data        - push request and its data
//   rd, r_data        - pop request; r_data is the head word (valid while empty=0)
//   af_th, ae_th      - almost-full / almost-empty thresholds in words
//   clr_err           - clears overflow/underflow (a same-cycle new error wins)
//   count             - words stored, 0..DEPTH
//   empty, full       - registered count==0 / count==DEPTH
//   almost_empty/full - count<=ae_th / count>=af_th, combinational on count
//   overflow          - sticky: wr while full with no accepted rd
//   underflow         - sticky: rd while empty
module fifo_buffer_ext
    import fifo_buffer_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    input  logic [ADDR_WIDTH:0]   af_th,
    input  logic [ADDR_WIDTH:0]   ae_th,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_ovf;
    logic                  r_unf;

    logic [ADDR_WIDTH-1:0] w_wptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rptr_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_ovf_nxt;
    logic                  w_unf_nxt;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    fifo_op_t              w_op;

    // Flush suppresses every read/write effect in its cycle, including errors.
    // A pop accepted in the same cycle frees a slot, so a push into a full FIFO
    // still goes through in that case.
    assign w_rd_ok   = rd & ~r_empty & ~flush;
    assign w_wr_ok   = wr & (~r_full | w_rd_ok) & ~flush;
    assign w_ovf_set = wr & r_full & ~w_rd_ok & ~flush;
    assign w_unf_set = rd & r_empty & ~flush;
    assign w_op      = decode_op(w_wr_ok, w_rd_ok);

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        if (flush) begin
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    w_wptr_nxt  = r_wptr + PTR_ONE;
                    w_count_nxt = r_count + CNT_ONE;
                end
                OP_POP: begin
                    w_rptr_nxt  = r_rptr + PTR_ONE;
                    w_count_nxt = r_count - CNT_ONE;
                end
                OP_BOTH: begin
                    w_wptr_nxt  = r_wptr + PTR_ONE;
                    w_rptr_nxt  = r_rptr + PTR_ONE;
                end
                default: ;
            endcase
            // Clear first so that a new error in the same cycle survives.
            if (clr_err) begin
                w_ovf_nxt = 1'b0;
                w_unf_nxt = 1'b0;
            end
            if (w_ovf_set) w_ovf_nxt = 1'b1;
            if (w_unf_set) w_unf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            // Flags come from the next count so they line up with count itself.
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == DEPTH_CNT);
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    fifo_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk     (clk),
        .i_we    (w_wr_ok & ~reset),
        .i_waddr (r_wptr),
        .i_wdata (w_data),
        .i_raddr (r_rptr),
        .o_rdata (r_data)
    );

    assign count        = r_count;
    assign empty        = r_empty;
    assign full         = r_full;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    // Thresholds above DEPTH simply never match for almost_full.
    assign almost_empty = (r_count <= ae_th);
    assign almost_full  = (r_count >= af_th);

endmodule
